// File: rtl/exe_stage_reg_if.sv
// EXE/MEM pipeline register bus: everything produced by the EXE stage going
// into the register, plus everything the register presents to the MEM stage
// and to the condition-check / ALU carry logic.
interface exe_stage_reg_if #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
);
    // Control from the hazard unit
    logic                      freeze;
    logic                      flush;

    // Instruction leaving the EXE stage
    logic                      in_valid;
    logic [WORD_WIDTH-1:0]     alu_res;
    logic [3:0]                alu_sr;
    logic                      s_update;
    logic                      wb_en_in;
    logic                      mem_r_en_in;
    logic                      mem_w_en_in;
    logic [REG_ADDR_WIDTH-1:0] dest_in;
    logic [WORD_WIDTH-1:0]     st_val_in;

    // Instruction held for the MEM stage
    logic                      out_valid;
    logic [WORD_WIDTH-1:0]     alu_res_out;
    logic [WORD_WIDTH-1:0]     st_val_out;
    logic [REG_ADDR_WIDTH-1:0] dest_out;
    logic                      wb_en_out;
    logic                      mem_r_en_out;
    logic                      mem_w_en_out;

    // Architectural state
    logic [3:0]                status;
    logic                      carry_out;
    logic [31:0]               retired_cnt;

    // Upstream side: drives the EXE results, observes the registered copy
    modport master (
        output freeze, flush, in_valid, alu_res, alu_sr, s_update,
               wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, st_val_in,
        input  out_valid, alu_res_out, st_val_out, dest_out,
               wb_en_out, mem_r_en_out, mem_w_en_out,
               status, carry_out, retired_cnt
    );

    // Register side
    modport slave (
        input  freeze, flush, in_valid, alu_res, alu_sr, s_update,
               wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, st_val_in,
        output out_valid, alu_res_out, st_val_out, dest_out,
               wb_en_out, mem_r_en_out, mem_w_en_out,
               status, carry_out, retired_cnt
    );
endinterface

// File: rtl/exe_stage_reg.sv
// EXE/MEM pipeline register. Captures the ALU result and memory/writeback
// controls each cycle, owns the architectural status flags {Z,C,N,V} and a
// retired-instruction counter. Edge priority: rst > flush > freeze > capture.
module exe_stage_reg #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    exe_stage_reg_if.slave    bus
);

    logic                      out_valid_q,    out_valid_d;
    logic [WORD_WIDTH-1:0]     alu_res_q,      alu_res_d;
    logic [WORD_WIDTH-1:0]     st_val_q,       st_val_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q,         dest_d;
    logic                      wb_en_q,        wb_en_d;
    logic                      mem_r_en_q,     mem_r_en_d;
    logic                      mem_w_en_q,     mem_w_en_d;
    logic [3:0]                status_q,       status_d;
    logic [31:0]               retired_cnt_q,  retired_cnt_d;

    // Next-state: flush kills only validity and enables (data and architectural
    // state hold), freeze holds everything, otherwise capture the EXE outputs.
    always_comb begin
        out_valid_d   = out_valid_q;
        alu_res_d     = alu_res_q;
        st_val_d      = st_val_q;
        dest_d        = dest_q;
        wb_en_d       = wb_en_q;
        mem_r_en_d    = mem_r_en_q;
        mem_w_en_d    = mem_w_en_q;
        status_d      = status_q;
        retired_cnt_d = retired_cnt_q;

        if (bus.flush) begin
            out_valid_d = 1'b0;
            wb_en_d     = 1'b0;
            mem_r_en_d  = 1'b0;
            mem_w_en_d  = 1'b0;
        end else if (!bus.freeze) begin
            out_valid_d = bus.in_valid;
            alu_res_d   = bus.alu_res;
            st_val_d    = bus.st_val_in;
            dest_d      = bus.dest_in;
            wb_en_d     = bus.wb_en_in    & bus.in_valid;
            mem_r_en_d  = bus.mem_r_en_in & bus.in_valid;
            mem_w_en_d  = bus.mem_w_en_in & bus.in_valid;
            if (bus.in_valid && bus.s_update) begin
                status_d = bus.alu_sr;
            end
            if (bus.in_valid) begin
                retired_cnt_d = retired_cnt_q + 32'd1;
            end
        end
    end

    // State register with synchronous reset clearing everything
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            alu_res_q     <= '0;
            st_val_q      <= '0;
            dest_q        <= '0;
            wb_en_q       <= 1'b0;
            mem_r_en_q    <= 1'b0;
            mem_w_en_q    <= 1'b0;
            status_q      <= 4'b0000;
            retired_cnt_q <= 32'd0;
        end else begin
            out_valid_q   <= out_valid_d;
            alu_res_q     <= alu_res_d;
            st_val_q      <= st_val_d;
            dest_q        <= dest_d;
            wb_en_q       <= wb_en_d;
            mem_r_en_q    <= mem_r_en_d;
            mem_w_en_q    <= mem_w_en_d;
            status_q      <= status_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Outputs come straight from the flops; carry is taken from the stored
    // status so an update is only visible the cycle after it is committed.
    assign bus.out_valid    = out_valid_q;
    assign bus.alu_res_out  = alu_res_q;
    assign bus.st_val_out   = st_val_q;
    assign bus.dest_out     = dest_q;
    assign bus.wb_en_out    = wb_en_q;
    assign bus.mem_r_en_out = mem_r_en_q;
    assign bus.mem_w_en_out = mem_w_en_q;
    assign bus.status       = status_q;
    assign bus.carry_out    = status_q[2];
    assign bus.retired_cnt  = retired_cnt_q;

endmodule

// File: doc/exe_stage_reg.md
EXE_STAGE_REG -- requirements
Module: exe_stage_reg

Interface
REQ-001 Parameter WORD_WIDTH, default 32: datapath width, matching the ALU result width.
REQ-002 Parameter REG_ADDR_WIDTH, default 4: register-file address width.
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 freeze  input  1  stall; hold all state this cycle.
REQ-006 flush  input  1  kill the instruction being captured this cycle.
REQ-007 in_valid  input  1  EXE stage holds a real instruction.
REQ-008 alu_res  input  WORD_WIDTH  ALU result, also the memory address for load/store.
REQ-009 alu_sr  input  4  ALU flags, bit order {Z,C,N,V}.
REQ-010 s_update  input  1  instruction's S bit; commit alu_sr to the status register.
REQ-011 wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  writeback, load and store enables.
REQ-012 dest_in  input  REG_ADDR_WIDTH  destination register.
REQ-013 st_val_in  input  WORD_WIDTH  store data (Rm value).
REQ-014 out_valid  output  1  MEM stage holds a real instruction.
REQ-015 alu_res_out, st_val_out  output  WORD_WIDTH  registered alu_res and st_val_in.
REQ-016 dest_out  output  REG_ADDR_WIDTH  registered dest_in.
REQ-017 wb_en_out, mem_r_en_out, mem_w_en_out  output  1 each  registered, validity-gated enables.
REQ-018 status  output  4  architectural status register {Z,C,N,V}, feeds condition check.
REQ-019 carry_out  output  1  status[2] (C), feeds the ALU carry input combinationally from the register.
REQ-020 retired_cnt  output  32  count of instructions captured valid.

Function
REQ-021 Priority per edge SHALL be rst > flush > freeze > normal capture.
REQ-022 Normal capture (no rst/flush/freeze): every output register SHALL load its input on the next edge; latency exactly 1 cycle.
REQ-023 out_valid SHALL load in_valid; wb_en_out, mem_r_en_out and mem_w_en_out SHALL load the matching input ANDed with in_valid.
REQ-024 The status register SHALL load alu_sr only when in_valid=1 and s_update=1 on a normal capture; otherwise it holds.
REQ-025 retired_cnt SHALL increment by 1 on a normal capture with in_valid=1, and wrap from 0xFFFFFFFF to 0.
REQ-026 Flush: out_valid and all three enables SHALL clear to 0; status and retired_cnt SHALL hold; data registers (alu_res_out, st_val_out, dest_out) SHALL hold.
REQ-027 Freeze (flush=0): every register, including status and retired_cnt, SHALL hold its value.
REQ-028 flush=1 and freeze=1 in the same cycle SHALL behave as flush only.
REQ-029 s_update=1 with in_valid=0 SHALL NOT change status.
REQ-030 mem_r_en_in and mem_w_en_in both 1 SHALL pass through unchanged; the block does not arbitrate.
REQ-031 carry_out SHALL reflect a status update from the first cycle after the updating edge; no same-cycle bypass.

Reset
REQ-032 On an edge with rst=1, all outputs SHALL become 0, including status=4'b0000, carry_out=0 and retired_cnt=0, regardless of freeze or flush.
REQ-033 Reset asserted mid-stall SHALL discard the held instruction; after release the first capture follows REQ-022.

Verification
REQ-034 Capture: in_valid=1, alu_res=0x0000_0010, dest_in=3, wb_en_in=1, s_update=0 -> next cycle alu_res_out=0x10, dest_out=3, wb_en_out=1, out_valid=1, status unchanged, retired_cnt +1.
REQ-035 Flags: in_valid=1, s_update=1, alu_sr=4'b0100 -> next cycle status=4'b0100, carry_out=1; then s_update=1 with in_valid=0 and alu_sr=4'b1000 -> status stays 4'b0100.
REQ-036 Freeze: load alu_res=0xAAAA_AAAA, then 3 cycles of freeze=1 with alu_res=0x5555_5555 and s_update=1 -> outputs, status and retired_cnt unchanged all 3 cycles; capture 0x5555_5555 on the first edge after freeze drops.
REQ-037 Flush with freeze: flush=1, freeze=1, in_valid=1, mem_w_en_in=1, s_update=1, alu_sr=4'b1111 -> out_valid=0, mem_w_en_out=0, status unchanged, retired_cnt unchanged.
REQ-038 Wrap: force retired_cnt to 0xFFFF_FFFF with valid captures, one more valid capture -> retired_cnt=0.
REQ-039 Reset: rst=1 while freeze=1 and status=4'b1111 -> next cycle all outputs 0; first valid capture after release sets retired_cnt=1.
